// File: rtl/alu_exec_stage_pkg.sv
// Shared Y86 execute-stage encodings: icodes, ifuns, condition codes, FSM
// state type and the branch/cmov condition evaluator.
package alu_exec_stage_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CXX    = 4'h2;
  localparam logic [3:0] I_IXX    = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADDQ   = 4'h0;
  localparam logic [3:0] F_SUBQ   = 4'h1;
  localparam logic [3:0] F_ANDQ   = 4'h2;
  localparam logic [3:0] F_XORQ   = 4'h3;
  localparam logic [3:0] F_MULQ   = 4'h4;
  // IXX with this ifun is a plain immediate move (valE = valC)
  localparam logic [3:0] F_IRMOVQ = 4'hF;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_MUL} state_t;

  // cc = {ZF,SF,OF}
  function automatic logic cond_eval(logic [3:0] fn, logic [2:0] cc);
    logic zf, sf, of;
    {zf, sf, of} = cc;
    case (fn)
      C_YES:   return 1'b1;
      C_LE:    return (sf ^ of) | zf;
      C_L:     return sf ^ of;
      C_E:     return zf;
      C_NE:    return ~zf;
      C_GE:    return ~(sf ^ of);
      C_G:     return ~(sf ^ of) & ~zf;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Decode->execute->memory stream bundle for the execute stage.
// slave = execute stage, master = surrounding pipeline (or bench).
interface alu_exec_stage_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ICODE_W    = 4,
  parameter int IFUN_W     = 4
);
  logic                  in_valid_i;
  logic                  in_ready_o;
  logic [ICODE_W-1:0]    E_icode_i;
  logic [IFUN_W-1:0]     E_ifun_i;
  logic [DATA_WIDTH-1:0] E_valC_i;
  logic [DATA_WIDTH-1:0] E_valA_i;
  logic [DATA_WIDTH-1:0] E_valB_i;
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [ICODE_W-1:0]    M_icode_o;
  logic [DATA_WIDTH-1:0] M_valE_o;
  logic [DATA_WIDTH-1:0] M_valA_o;
  logic                  M_cnd_o;
  logic [2:0]            cc_o;
  logic                  busy_o;

  modport master (
    output in_valid_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i, out_ready_i,
    input  in_ready_o, out_valid_o, M_icode_o, M_valE_o, M_valA_o, M_cnd_o, cc_o, busy_o
  );
  modport slave (
    input  in_valid_i, E_icode_i, E_ifun_i, E_valC_i, E_valA_i, E_valB_i, out_ready_i,
    output in_ready_o, out_valid_o, M_icode_o, M_valE_o, M_valA_o, M_cnd_o, cc_o, busy_o
  );
endinterface

// File: rtl/alu_exec_stage_core.sv
// Combinational ALU: res = b <fun> a with ZF/SF/OF. fun_ok flags a
// supported function; anything else yields res=0 and must not touch CC.
module alu_core
  import alu_exec_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int IFUN_W     = 4
) (
  input  logic [IFUN_W-1:0]     fun,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  zf,
  output logic                  sf,
  output logic                  of,
  output logic                  fun_ok
);
  localparam int MSB = DATA_WIDTH - 1;

  // function select, flags derived from the chosen result
  always_comb begin
    res    = '0;
    of     = 1'b0;
    fun_ok = 1'b1;
    case (fun)
      F_ADDQ: begin
        res = b + a;
        of  = (a[MSB] == b[MSB]) && (res[MSB] != b[MSB]);
      end
      F_SUBQ: begin
        res = b - a;
        of  = (a[MSB] != b[MSB]) && (res[MSB] != b[MSB]);
      end
      F_ANDQ:  res = b & a;
      F_XORQ:  res = b ^ a;
      default: fun_ok = 1'b0;
    endcase
    zf = (res == '0);
    sf = res[MSB];
  end
endmodule

// File: rtl/alu_exec_stage.sv
// Y86 registered execute stage: operand select, valE, CC register, cnd,
// valid/ready toward the memory stage.
// Optional iterative shift-add multiply (OPQ ifun MULQ) under `ALU_MULQ_EN.
module alu_exec_stage
  import alu_exec_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int STACK_STEP = 8,
  parameter int ICODE_W    = 4,
  parameter int IFUN_W     = 4
) (
  input logic              clk_i,
  input logic              rst_n_i,
  input logic              flush_i,
  input logic              cc_hold_i,
  alu_exec_stage_if.slave  io
);
  localparam int MSB = DATA_WIDTH - 1;

  state_t                state_q, state_d;
  logic [2:0]            cc_q;
  logic                  accept, is_mul, mul_done, cc_upd, cnd_d;
  logic [ICODE_W-1:0]    icode;
  logic [IFUN_W-1:0]     ifun;
  logic [DATA_WIDTH-1:0] core_a, core_res, vale_d;
  logic                  core_zf, core_sf, core_of, core_ok;

  assign icode  = io.E_icode_i;
  assign ifun   = io.E_ifun_i;
  assign accept = io.in_valid_i && io.in_ready_o;

  // IXX substitutes the immediate for valA as the second operand
  assign core_a = (icode == I_IXX) ? io.E_valC_i : io.E_valA_i;

  alu_core #(.DATA_WIDTH(DATA_WIDTH), .IFUN_W(IFUN_W)) u_core (
    .fun(ifun), .a(core_a), .b(io.E_valB_i),
    .res(core_res), .zf(core_zf), .sf(core_sf), .of(core_of), .fun_ok(core_ok)
  );

  // valE per icode; cc_upd marks arithmetic that is allowed to write CC
  always_comb begin
    vale_d = '0;
    cc_upd = 1'b0;
    case (icode)
      I_OPQ: begin
        vale_d = core_res;
        cc_upd = core_ok;
      end
      I_IXX: begin
        if (ifun == F_IRMOVQ) vale_d = io.E_valC_i;
        else begin
          vale_d = core_res;
          cc_upd = core_ok;
        end
      end
      I_RMMOVQ, I_MRMOVQ: vale_d = io.E_valB_i + io.E_valC_i;
      I_CALL, I_PUSHQ:    vale_d = io.E_valB_i - DATA_WIDTH'(STACK_STEP);
      I_RET, I_POPQ:      vale_d = io.E_valB_i + DATA_WIDTH'(STACK_STEP);
      I_CXX:              vale_d = io.E_valA_i;
      default:            vale_d = '0;
    endcase
  end

  // condition sees CC as it stood before this cycle's write
  assign cnd_d = ((icode == I_CXX) || (icode == I_JXX)) ? cond_eval(ifun, cc_q) : 1'b1;

`ifdef ALU_MULQ_EN
  localparam int CW = $clog2(DATA_WIDTH);

  logic [2*DATA_WIDTH-1:0] mul_acc_q, mul_mcand_q, mul_acc_nxt;
  logic [DATA_WIDTH-1:0]   mul_mplier_q, mul_b_q, mul_lo, mul_hi;
  logic [CW-1:0]           mul_cnt_q;
  logic                    mul_of;

  assign is_mul   = (icode == I_OPQ) && (ifun == F_MULQ);
  assign mul_done = (state_q == ST_MUL) && (mul_cnt_q == CW'(DATA_WIDTH - 1));

  // one partial product per cycle; high half corrected to signed for OF
  always_comb begin
    mul_acc_nxt = mul_acc_q + (mul_mplier_q[0] ? mul_mcand_q : '0);
    mul_lo      = mul_acc_nxt[DATA_WIDTH-1:0];
    mul_hi      = mul_acc_nxt[2*DATA_WIDTH-1:DATA_WIDTH]
                - (io.M_valA_o[MSB] ? mul_b_q : '0)
                - (mul_b_q[MSB] ? io.M_valA_o : '0);
    mul_of      = (mul_hi != {DATA_WIDTH{mul_lo[MSB]}});
  end

  // multiplier operand/accumulator registers; M_valA_o holds valA
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= '0;
      mul_mplier_q <= '0;
      mul_b_q      <= '0;
      mul_cnt_q    <= '0;
    end else if (accept && is_mul) begin
      mul_acc_q    <= '0;
      mul_mcand_q  <= {{DATA_WIDTH{1'b0}}, io.E_valB_i};
      mul_mplier_q <= io.E_valA_i;
      mul_b_q      <= io.E_valB_i;
      mul_cnt_q    <= '0;
    end else if (state_q == ST_MUL) begin
      mul_acc_q    <= mul_acc_nxt;
      mul_mcand_q  <= mul_mcand_q << 1;
      mul_mplier_q <= mul_mplier_q >> 1;
      mul_cnt_q    <= mul_cnt_q + 1'b1;
    end
  end
`else
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  // next state; flush wins over everything
  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = ST_EMPTY;
    else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = is_mul ? ST_MUL : ST_FULL;
        ST_FULL: begin
          if (accept)              state_d = is_mul ? ST_MUL : ST_FULL;
          else if (io.out_ready_i) state_d = ST_EMPTY;
        end
`ifdef ALU_MULQ_EN
        ST_MUL: if (mul_done) state_d = ST_FULL;
`endif
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // handshake outputs decoded from state
  always_comb begin
    io.out_valid_o = (state_q == ST_FULL);
`ifdef ALU_MULQ_EN
    io.busy_o      = (state_q == ST_MUL);
`else
    io.busy_o      = 1'b0;
`endif
    io.in_ready_o  = (state_q != ST_MUL) && (!io.out_valid_o || io.out_ready_i);
  end

  // M-stage registers: load on accept (or multiply completion), else hold
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      io.M_icode_o <= '0;
      io.M_valE_o  <= '0;
      io.M_valA_o  <= '0;
      io.M_cnd_o   <= 1'b0;
    end else if (!flush_i) begin
      if (accept) begin
        io.M_icode_o <= icode;
        io.M_valE_o  <= is_mul ? '0 : vale_d;
        io.M_valA_o  <= io.E_valA_i;
        io.M_cnd_o   <= cnd_d;
      end
`ifdef ALU_MULQ_EN
      else if (mul_done) io.M_valE_o <= mul_lo;
`endif
    end
  end

  // condition-code register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cc_q <= 3'b100;
    else if (!flush_i && !cc_hold_i) begin
      if (accept && cc_upd) cc_q <= {core_zf, core_sf, core_of};
`ifdef ALU_MULQ_EN
      else if (mul_done) cc_q <= {(mul_lo == '0), mul_lo[MSB], mul_of};
`endif
    end
  end

  assign io.cc_o = cc_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus random
// traffic against a spec-level reference model. Multiply scenarios are
// compiled in when ALU_MULQ_EN is defined.
module tb_alu_exec_stage;
  import alu_exec_stage_pkg::*;

  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic cc_hold = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_exec_stage_if #(.DATA_WIDTH(DW)) io ();

  alu_exec_stage #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .cc_hold_i(cc_hold), .io(io)
  );

  // reference model state
  bit          mv;
  logic [63:0] mvale, mvala;
  logic [3:0]  micode;
  bit          mcnd;
  logic [2:0]  mcc;
  bit          exp_rdy, obs_rdy;

  task automatic drive(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input bit v, input bit r);
    io.E_icode_i = ic; io.E_ifun_i = fn;
    io.E_valA_i = a; io.E_valB_i = b; io.E_valC_i = c;
    io.in_valid_i = v; io.out_ready_i = r;
  endtask

  // true two's-complement arithmetic; OF = exact result outside 64-bit range
  task automatic model_alu(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c,
                           output logic [63:0] r, output bit wr, output logic [2:0] ccn);
    logic [63:0] y;
    logic signed [65:0] s;
    bit ofl;
    r = '0; wr = 0; ofl = 0;
    case (ic)
      I_OPQ, I_IXX: begin
        y = (ic == I_IXX) ? c : a;
        if (ic == I_IXX && fn == F_IRMOVQ) r = c;
        else begin
          wr = 1;
          case (fn)
            F_ADDQ: begin
              s = $signed({{2{b[63]}}, b}) + $signed({{2{y[63]}}, y});
              r = s[63:0]; ofl = (s != $signed({{2{r[63]}}, r}));
            end
            F_SUBQ: begin
              s = $signed({{2{b[63]}}, b}) - $signed({{2{y[63]}}, y});
              r = s[63:0]; ofl = (s != $signed({{2{r[63]}}, r}));
            end
            F_ANDQ:  r = b & y;
            F_XORQ:  r = b ^ y;
            default: begin r = '0; wr = 0; end
          endcase
        end
      end
      I_RMMOVQ, I_MRMOVQ: r = b + c;
      I_CALL, I_PUSHQ:    r = b - 64'd8;
      I_RET, I_POPQ:      r = b + 64'd8;
      I_CXX:              r = a;
      default:            r = '0;
    endcase
    ccn = {r == 64'd0, r[63], ofl};
  endtask

  function automatic bit model_cnd(input logic [3:0] ic, input logic [3:0] fn, input logic [2:0] cc);
    bit z, s, o;
    z = cc[2]; s = cc[1]; o = cc[0];
    if (ic != I_CXX && ic != I_JXX) return 1;
    case (fn)
      4'd0: return 1;
      4'd1: return (s != o) || z;
      4'd2: return s != o;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return s == o;
      4'd6: return (s == o) && !z;
      default: return 0;
    endcase
  endfunction

  // advance one clock with the currently driven inputs and update the model
  task automatic tick();
    logic [63:0] r;
    bit wr, acc;
    logic [2:0] ccn;
    #1;
    obs_rdy = io.in_ready_o;
    exp_rdy = !mv || io.out_ready_i;
    acc = io.in_valid_i && exp_rdy;
    model_alu(io.E_icode_i, io.E_ifun_i, io.E_valA_i, io.E_valB_i, io.E_valC_i, r, wr, ccn);
    if (flush) mv = 0;
    else if (acc) begin
      mcnd = model_cnd(io.E_icode_i, io.E_ifun_i, mcc);
      mv = 1; mvale = r; mvala = io.E_valA_i; micode = io.E_icode_i;
      if (wr && !cc_hold) mcc = ccn;
    end else if (mv && io.out_ready_i) mv = 0;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return '1;
      4: return 64'($urandom_range(0, 16));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_reset();
    drive(I_NOP, 4'd0, '0, '0, '0, 0, 1);
    rst_n = 0; #12;
    checks++; if (io.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", io.out_valid_o); end
    checks++; if (io.cc_o !== 3'b100) begin failures++; $display("FAIL rst_cc got=%b exp=100", io.cc_o); end
    checks++; if ({io.M_valE_o, io.M_valA_o} !== 128'd0) begin failures++; $display("FAIL rst_vals got=%h_%h exp=0", io.M_valE_o, io.M_valA_o); end
    checks++; if ({io.M_icode_o, io.M_cnd_o, io.busy_o} !== 6'd0) begin failures++; $display("FAIL rst_misc got=%h/%b/%b exp=0", io.M_icode_o, io.M_cnd_o, io.busy_o); end
    checks++; if (io.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", io.in_ready_o); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    mv = 0; mcc = 3'b100;
  endtask

  task automatic test_add_overflow();
    drive(I_OPQ, F_ADDQ, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, '0, 1, 1);
    tick();
    checks++; if (io.out_valid_o !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", io.out_valid_o); end
    checks++; if (io.M_valE_o !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL add_vale got=%h exp=8000000000000000", io.M_valE_o); end
    checks++; if (io.cc_o !== 3'b011) begin failures++; $display("FAIL add_cc got=%b exp=011", io.cc_o); end
  endtask

  task automatic test_sub_cmov();
    drive(I_OPQ, F_SUBQ, 64'd5, 64'd5, '0, 1, 1);
    tick();
    checks++; if (io.cc_o !== 3'b100 || io.M_valE_o !== 64'd0) begin failures++; $display("FAIL sub_cc got=%b/%h exp=100/0", io.cc_o, io.M_valE_o); end
    drive(I_CXX, C_E, 64'h1234, 64'd9, '0, 1, 1);
    tick();
    checks++; if (io.M_valE_o !== 64'h1234 || io.M_cnd_o !== 1'b1) begin failures++; $display("FAIL cmove got=%h/%b exp=1234/1", io.M_valE_o, io.M_cnd_o); end
    drive(I_CXX, C_NE, 64'h55, 64'd9, '0, 1, 1);
    tick();
    checks++; if (io.M_valE_o !== 64'h55 || io.M_cnd_o !== 1'b0) begin failures++; $display("FAIL cmovne got=%h/%b exp=55/0", io.M_valE_o, io.M_cnd_o); end
  endtask

  task automatic test_push_stall();
    drive(I_PUSHQ, 4'd0, '0, 64'h100, '0, 1, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(I_OPQ, F_ADDQ, {$urandom, $urandom}, {$urandom, $urandom}, '0, 1, 0);
      tick();
      checks++; if (io.out_valid_o !== 1'b1 || io.M_valE_o !== 64'hF8 || io.M_icode_o !== I_PUSHQ) begin
        failures++; $display("FAIL push_hold got=%b/%h/%h exp=1/f8/a", io.out_valid_o, io.M_valE_o, io.M_icode_o); end
      checks++; if (obs_rdy !== 1'b0) begin failures++; $display("FAIL push_ready got=%b exp=0", obs_rdy); end
    end
    drive(I_NOP, 4'd0, '0, '0, '0, 0, 1);
    tick();
    checks++; if (io.out_valid_o !== 1'b0) begin failures++; $display("FAIL push_release got=%b exp=0", io.out_valid_o); end
  endtask

  task automatic test_cc_hold();
    drive(I_OPQ, F_ADDQ, 64'd1, 64'd1, '0, 1, 1);
    tick();
    cc_hold = 1;
    drive(I_IXX, F_ADDQ, '0, 64'd1, '1, 1, 1);
    tick();
    cc_hold = 0;
    checks++; if (io.M_valE_o !== 64'd0 || io.out_valid_o !== 1'b1) begin failures++; $display("FAIL hold_vale got=%h/%b exp=0/1", io.M_valE_o, io.out_valid_o); end
    checks++; if (io.cc_o !== 3'b000) begin failures++; $display("FAIL hold_cc got=%b exp=000", io.cc_o); end
  endtask

  task automatic test_flush();
    drive(I_OPQ, F_SUBQ, 64'd2, 64'd1, '0, 1, 1);
    tick();
    flush = 1;
    drive(I_OPQ, F_XORQ, 64'h77, 64'h77, '0, 1, 1);
    tick();
    flush = 0;
    checks++; if (io.out_valid_o !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", io.out_valid_o); end
    checks++; if (io.cc_o !== 3'b010) begin failures++; $display("FAIL flush_cc got=%b exp=010", io.cc_o); end
  endtask

  task automatic test_undef_ifun();
    logic [3:0] fns [$];
    fns.push_back(4'd7);
`ifndef ALU_MULQ_EN
    fns.push_back(F_MULQ);
`endif
    foreach (fns[k]) begin
      drive(I_OPQ, fns[k], 64'd3, 64'd3, '0, 1, 1);
      tick();
      checks++; if (io.M_valE_o !== 64'd0 || io.cc_o !== mcc) begin
        failures++; $display("FAIL undef_ifun%0d got=%h/%b exp=0/%b", fns[k], io.M_valE_o, io.cc_o, mcc); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      drive(I_OPQ, 4'($urandom_range(0, 1)), rnd64(), rnd64(), '0, 1, 1);
      tick();
      checks++; if (io.out_valid_o !== 1'b1 || io.M_valE_o !== mvale || io.cc_o !== mcc || obs_rdy !== 1'b1) begin
        failures++; $display("FAIL b2b[%0d] got=%b/%h/%b/%b exp=1/%h/%b/1", i, io.out_valid_o, io.M_valE_o, io.cc_o, obs_rdy, mvale, mcc); end
    end
  endtask

  task automatic test_random();
    logic [3:0] ic, fn;
    for (int i = 0; i < 400; i++) begin
      ic = 4'($urandom_range(0, 15));
      fn = 4'($urandom_range(0, 7));
      if (ic == I_IXX && $urandom_range(0, 3) == 0) fn = F_IRMOVQ;
`ifdef ALU_MULQ_EN
      if (ic == I_OPQ && fn == F_MULQ) fn = 4'd5;
`endif
      flush   = ($urandom_range(0, 15) == 0);
      cc_hold = ($urandom_range(0, 7) == 0);
      drive(ic, fn, rnd64(), rnd64(), rnd64(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      tick();
      checks++; if (io.out_valid_o !== mv || obs_rdy !== exp_rdy || io.cc_o !== mcc) begin
        failures++; $display("FAIL rnd_ctl[%0d] got=%b/%b/%b exp=%b/%b/%b", i, io.out_valid_o, obs_rdy, io.cc_o, mv, exp_rdy, mcc); end
      if (mv) begin
        checks++; if (io.M_valE_o !== mvale || io.M_valA_o !== mvala || io.M_icode_o !== micode || io.M_cnd_o !== mcnd) begin
          failures++; $display("FAIL rnd_data[%0d] got=%h/%h/%h/%b exp=%h/%h/%h/%b", i, io.M_valE_o, io.M_valA_o, io.M_icode_o, io.M_cnd_o, mvale, mvala, micode, mcnd); end
      end
    end
    flush = 0; cc_hold = 0;
    drive(I_NOP, 4'd0, '0, '0, '0, 0, 1);
    tick();
  endtask

`ifdef ALU_MULQ_EN
  task automatic test_mulq();
    logic [63:0] av [3];
    logic [63:0] bv [3];
    logic signed [127:0] p;
    logic [63:0] lo;
    logic [2:0] ecc;
    int n;
    bit rdy_bad;
    av[0] = 64'd3;          bv[0] = 64'd7;
    av[1] = 64'h1_0000_0000; bv[1] = 64'h1_0000_0000;
    av[2] = -64'sd3;        bv[2] = 64'd7;
    for (int k = 0; k < 3; k++) begin
      p = $signed({{64{av[k][63]}}, av[k]}) * $signed({{64{bv[k][63]}}, bv[k]});
      lo = p[63:0];
      ecc = {lo == 64'd0, lo[63], p != $signed({{64{lo[63]}}, lo})};
      drive(I_OPQ, F_MULQ, av[k], bv[k], '0, 1, 1);
      @(posedge clk); #1;
      drive(I_NOP, 4'd0, '0, '0, '0, 0, 1);
      n = 0; rdy_bad = 0;
      while (io.busy_o === 1'b1 && n < 200) begin
        if (io.in_ready_o !== 1'b0) rdy_bad = 1;
        n++;
        @(posedge clk); #1;
      end
      checks++; if (n != 64 || rdy_bad) begin failures++; $display("FAIL mul_busy[%0d] got=%0d/%b exp=64/0", k, n, rdy_bad); end
      checks++; if (io.out_valid_o !== 1'b1 || io.M_valE_o !== lo || io.cc_o !== ecc) begin
        failures++; $display("FAIL mul_res[%0d] got=%b/%h/%b exp=1/%h/%b", k, io.out_valid_o, io.M_valE_o, io.cc_o, lo, ecc); end
      @(posedge clk); #1;
      mv = 0; mcc = ecc;
    end
    drive(I_OPQ, F_MULQ, 64'd3, 64'd7, '0, 1, 1);
    @(posedge clk); #1;
    drive(I_NOP, 4'd0, '0, '0, '0, 0, 1);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    checks++; if (io.busy_o !== 1'b0 || io.out_valid_o !== 1'b0 || io.in_ready_o !== 1'b1 || io.cc_o !== mcc) begin
      failures++; $display("FAIL mul_flush got=%b/%b/%b/%b exp=0/0/1/%b", io.busy_o, io.out_valid_o, io.in_ready_o, io.cc_o, mcc); end
    repeat (70) begin @(posedge clk); #1; end
    checks++; if (io.out_valid_o !== 1'b0) begin failures++; $display("FAIL mul_flush_late got=%b exp=0", io.out_valid_o); end
  endtask
`endif

  task automatic test_reset_mid();
    drive(I_OPQ, F_ADDQ, 64'd5, 64'd7, '0, 1, 0);
    tick();
    #3 rst_n = 0;
    #1;
    checks++; if (io.out_valid_o !== 1'b0 || io.cc_o !== 3'b100 || io.M_valE_o !== 64'd0) begin
      failures++; $display("FAIL rst_mid got=%b/%b/%h exp=0/100/0", io.out_valid_o, io.cc_o, io.M_valE_o); end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    mv = 0; mcc = 3'b100;
  endtask

  initial begin
    mv = 0; mcc = 3'b100;
    test_reset();
    test_add_overflow();
    test_sub_cmov();
    test_push_stall();
    test_cc_hold();
    test_flush();
    test_undef_ifun();
    test_back_to_back();
`ifdef ALU_MULQ_EN
    test_mulq();
`endif
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
Registered execute stage for the Y86 pipeline, parametrised in data width. It selects ALU operands per icode, computes valE, and maintains the condition-code register (ZF/SF/OF). It evaluates the cmov/jump condition (cnd) and presents results to the memory stage over a valid/ready handshake. It also supports immediate arithmetic (IXX with ifun other than IRMOVQ) and an optional iterative multiply.

Parameters:
DATA_WIDTH, 64, width of valA/valB/valC/valE
STACK_STEP, 8, byte step applied to %rsp by CALL/RET/PUSHQ/POPQ
ICODE_W, 4, icode width
IFUN_W, 4, ifun width

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  bubble request from the hazard unit; kills the in-flight and accepted-this-cycle instruction
cc_hold_i  in  1  suppresses any CC write (m/W stage exception)
in_valid_i  in  1  decode-stage instruction valid
in_ready_o  out  1  stage can accept
E_icode_i  in  ICODE_W  instruction code
E_ifun_i  in  IFUN_W  function code
E_valC_i / E_valA_i / E_valB_i  in  DATA_WIDTH  operands
out_valid_o  out  1  M-stage result valid
out_ready_i  in  1  memory stage accepts
M_icode_o  out  ICODE_W  registered icode
M_valE_o  out  DATA_WIDTH  ALU result
M_valA_o  out  DATA_WIDTH  pass-through valA
M_cnd_o  out  1  condition outcome
cc_o  out  3  {ZF,SF,OF}
busy_o  out  1  multiply in progress

Behaviour:
- Reset: out_valid_o=0, M_*=0, M_cnd_o=0, busy_o=0, cc_o=3'b100 (ZF=1), FSM=EMPTY.
- FSM states: EMPTY, FULL, MUL.
- in_ready_o = (state!=MUL) && (!out_valid_o || out_ready_i).
- Accept when in_valid_i && in_ready_o. Result is registered with 1-cycle latency (MUL excluded).
- valE by icode, all modulo 2^DATA_WIDTH:
  - OPQ: ADDQ valB+valA; SUBQ valB-valA; ANDQ valB&valA; XORQ valB^valA.
  - IXX: ifun==IRMOVQ gives valC; otherwise the OPQ function applied to valB op valC.
  - RMMOVQ/MRMOVQ: valB+valC.
  - CALL/PUSHQ: valB-STACK_STEP.
  - RET/POPQ: valB+STACK_STEP.
  - CXX: valA.
  - Other icodes (incl. JXX, NOP, HALT): 0.
- CC written on accept only for OPQ and for non-IRMOVQ IXX, and only when !cc_hold_i && !flush_i.
  - ZF = (res==0); SF = res[MSB].
  - OF add: operands share a sign and res sign differs.
  - OF sub: valB, valA signs differ and res sign != valB sign.
  - AND/XOR: OF=0.
- cnd for CXX/JXX uses the CC register value before this cycle's update. By ifun: 0 always; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; other 0. For non-conditional icodes cnd=1.
- Undefined ifun for OPQ/IXX: valE=0, no CC write.
- Transitions:
  - EMPTY→FULL on accept.
  - FULL→EMPTY when out_ready_i with no new accept.
  - FULL→FULL on accept with out_ready_i.
  - Output registers hold stable while out_valid_o && !out_ready_i.
- flush_i (highest priority): next cycle out_valid_o=0, state EMPTY, no CC write, multiply aborted, busy_o=0. The instruction presented that cycle is dropped.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
ALU_MULQ_EN.
- Defined: OPQ ifun MULQ (4) is accepted into state MUL with busy_o=1. It runs a shift-add of valB*valA over DATA_WIDTH cycles using a counter, then enters FULL with the low DATA_WIDTH bits.
  - ZF/SF set from the result; OF=1 if the signed product does not fit.
  - in_ready_o=0 throughout.
- Undefined: ifun 4 is treated as undefined (valE=0, no CC write). MUL state and counter are not synthesised; busy_o is tied 0.

Decomposition:
- Shared package / define.v holds the icode constants (OPQ, IXX, CXX, JXX, RMMOVQ, MRMOVQ, CALL, RET, PUSHQ, POPQ), the ifun constants (ADDQ, SUBQ, ANDQ, XORQ, MULQ, IRMOVQ) and the condition encodings.
- One sub-module, alu_core: combinational result plus ZF/SF/OF for a given fun. It is instantiated once.
- FSM, CC register, cnd logic and multiplier stay in alu_exec_stage.

Test Plan:
- Reset then OPQ ADDQ with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1, out_ready=1 → next cycle valE=0x8000_0000_0000_0000, cc={0,1,1}.
- OPQ SUBQ with valA=5, valB=5, then CXX ifun 3 (e) with valA=0x1234 → cc={1,0,0}; CXX result valE=0x1234, cnd=1.
- PUSHQ valB=0x100 with out_ready_i=0 for 3 cycles → valE=0xF8 held stable, in_ready_o=0, then released on out_ready_i=1.
- IXX ifun ADDQ with valC=-1, valB=1, cc_hold_i=1 → valE=0, cc unchanged from the prior value.
- OPQ XORQ accepted while flush_i=1 → out_valid_o=0 next cycle, no CC change.
- With ALU_MULQ_EN: MULQ valA=3, valB=7 → busy_o high for 64 cycles, then valE=21, cc={0,0,0}. A flush at cycle 10 aborts with busy_o=0.
